// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the detector benches that
// consume its output.
//   - feeder_state_e : one-bit FSM encoding (ST_IDLE / ST_SHIFT)
//   - DEF_*          : default parameter values for feeder instances
package serial_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feeder_state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DIV        = 1;
    localparam bit DEF_MSB_FIRST  = 1'b1;
    localparam bit DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_bit_tick_gen.sv
// Bit-period divider for the serial feeder.
// Counts 0..DIV-1 while enabled and qualifies the first and last cycle of each
// serial bit period.
//   clk, reset  : clock and synchronous active-low reset
//   enable      : count while high (feeder is shifting); held at 0 otherwise
//   clear       : restart the bit period (a word is being loaded this edge)
//   tick_first  : current cycle is the first of a bit period
//   tick_last   : current cycle is the last of a bit period
module bit_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick_first,
    output logic tick_last
);

    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_first = (div_q == '0);
    assign tick_last  = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (clear || !enable) begin
            div_d = '0;
        end else if (tick_last) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence-detector FSMs.
// Accepts WIDTH-bit words over valid/ready, keeps one word of buffering so
// consecutive words stream without a gap, and shifts each word out on dout,
// one bit every DIV clock cycles.
//   clk, reset  : clock and synchronous active-low reset
//   data_in     : word to serialize, captured on accept
//   data_valid  : upstream word valid
//   data_ready  : a word can be taken (hold register empty, not in reset)
//   dout        : registered serial stream, IDLE_LEVEL when not shifting
//   bit_strobe  : first cycle of each new bit on dout
//   word_done   : final cycle of a word's last bit
//   busy        : shifter holds a word
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DIV        = DEF_DIV,
    parameter bit MSB_FIRST  = DEF_MSB_FIRST,
    parameter bit IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             dout,
    output logic             bit_strobe,
    output logic             word_done,
    output logic             busy
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_bit_feeder: WIDTH must be within 2..32");
        end
        if (DIV < 1 || DIV > 256) begin : g_bad_div
            $error("serial_bit_feeder: DIV must be within 1..256");
        end
    endgenerate

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    feeder_state_e    state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dout_q, dout_d;

    logic             tick_first;
    logic             tick_last;
    logic             shifting;
    logic             last_tick;
    logic             accept;
    logic             load_direct;
    logic             load_hold;
    logic             load;
    logic             hold_write;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shifted_word;

    // Ready is gated by reset directly so nothing can be accepted in the
    // same edge that clears the block.
    assign data_ready = reset && !hold_full_q;
    assign accept     = data_valid && data_ready;

    assign shifting  = (state_q == ST_SHIFT);
    assign last_tick = shifting && tick_last && (bit_cnt_q == LAST_BIT);

    // A new word goes straight into the shifter when it is free now or frees
    // up this very edge; otherwise it waits in the hold register. While the
    // hold is full data_ready is low, so a hold drain never meets an accept.
    assign load_direct = accept && (!shifting || last_tick);
    assign hold_write  = accept && shifting && !last_tick;
    assign load_hold   = last_tick && hold_full_q;
    assign load        = load_direct || load_hold;
    assign load_word   = load_hold ? hold_q : data_in;

    assign shifted_word = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shift_q[WIDTH-1:1]};

    bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .enable    (shifting),
        .clear     (load),
        .tick_first(tick_first),
        .tick_last (tick_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_tick && !load) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = shifting;
        bit_strobe = shifting && tick_first;
        word_done  = last_tick;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        if (load) begin
            shift_d   = load_word;
            bit_cnt_d = '0;
        end else if (shifting && tick_last) begin
            shift_d   = shifted_word;
            bit_cnt_d = last_tick ? '0 : bit_cnt_q + CNT_W'(1);
        end

        if (hold_write) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end else if (load_hold) begin
            hold_full_d = 1'b0;
        end

        // dout is registered: it shows the bit that the shifter will hold
        // after this edge, so the first bit appears the cycle after load.
        if (state_d == ST_SHIFT) begin
            dout_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end else begin
            dout_d = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            dout_q      <= IDLE_LEVEL;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            dout_q      <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder. Four instances cover the parameter
// variants; a small 10011 detector hangs off the WIDTH=5 instance.
// Status vectors are {dout, bit_strobe, word_done, busy, data_ready}.
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // A: WIDTH=8, DIV=1, MSB first
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_dout, a_strobe, a_done, a_busy;
    // B: WIDTH=4, DIV=3, MSB first
    logic [3:0] b_data;
    logic       b_valid, b_ready, b_dout, b_strobe, b_done, b_busy;
    // C: WIDTH=8, DIV=1, LSB first
    logic [7:0] c_data;
    logic       c_valid, c_ready, c_dout, c_strobe, c_done, c_busy;
    // D: WIDTH=5, DIV=1, MSB first, feeds the detector
    logic [4:0] d_data;
    logic       d_valid, d_ready, d_dout, d_strobe, d_done, d_busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_bit_feeder #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .dout(a_dout), .bit_strobe(a_strobe),
        .word_done(a_done), .busy(a_busy));

    serial_bit_feeder #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .dout(b_dout), .bit_strobe(b_strobe),
        .word_done(b_done), .busy(b_busy));

    serial_bit_feeder #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_c (
        .clk(clk), .reset(reset), .data_in(c_data), .data_valid(c_valid),
        .data_ready(c_ready), .dout(c_dout), .bit_strobe(c_strobe),
        .word_done(c_done), .busy(c_busy));

    serial_bit_feeder #(.WIDTH(5), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_d (
        .clk(clk), .reset(reset), .data_in(d_data), .data_valid(d_valid),
        .data_ready(d_ready), .dout(d_dout), .bit_strobe(d_strobe),
        .word_done(d_done), .busy(d_busy));

    // 10011 detector: pulses the cycle after the edge that takes the final 1.
    logic [3:0] det_hist_q;
    logic       seq_detected;
    always_ff @(posedge clk) begin
        if (!reset) begin
            det_hist_q   <= '0;
            seq_detected <= 1'b0;
        end else begin
            seq_detected <= d_busy && ({det_hist_q, d_dout} == 5'b10011);
            if (d_busy) det_hist_q <= {det_hist_q[2:0], d_dout};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serialize one 8-bit word on instance A, MSB first, and check 9 cycles.
    task automatic run_a_word(input string name, input logic [7:0] w);
        @(negedge clk);
        a_data  = w;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        a_data = ~w;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s c%0d", name, k),
                     {a_dout, a_strobe, a_done, a_busy, a_ready},
                     {w[8-k], 1'b1, (k == 8), 1'b1, 1'b1});
        end
        @(negedge clk);
        check_eq($sformatf("%s c9", name), {a_dout, a_strobe, a_done, a_busy, a_ready}, 5'b00001);
        $display("word %s %h serialized", name, w);
    endtask

    initial begin
        logic [3:0] wb;
        logic [7:0] wa;
        reset   = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;
        a_data  = '0;   b_data  = '0;   c_data  = '0;   d_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst A", {a_dout, a_strobe, a_done, a_busy, a_ready}, 5'b00000);
        check_eq("rst B", {b_dout, b_strobe, b_done, b_busy, b_ready}, 5'b00000);
        check_eq("rst C", {c_dout, c_strobe, c_done, c_busy, c_ready}, 5'b00000);
        check_eq("rst D", {d_dout, d_strobe, d_done, d_busy, d_ready}, 5'b00000);
        reset = 1'b1;
        @(negedge clk);
        check_eq("post-rst ready", {a_ready, b_ready, c_ready, d_ready}, 4'b1111);

        // 1: single word A5
        run_a_word("t1", 8'hA5);

        // 2: back-to-back FF then 00 with data_valid held
        @(negedge clk);
        a_data  = 8'hFF;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_data = 8'h00;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check_eq($sformatf("t2 c%0d", k),
                     {a_dout, a_strobe, a_done, a_busy, a_ready},
                     {(k <= 8), (k <= 16), (k == 8 || k == 16), (k <= 16), (k == 1 || k >= 9)});
            if (k == 1) begin
                @(posedge clk);
                #1 a_valid = 1'b0;
            end
        end
        $display("words t2 ff,00 serialized");

        // 3: DIV=3, WIDTH=4, 1010
        wb = 4'b1010;
        @(negedge clk);
        b_data  = wb;
        b_valid = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k <= 12)
                check_eq($sformatf("t3 c%0d", k),
                         {b_dout, b_strobe, b_done, b_busy, b_ready},
                         {wb[3 - (k - 1) / 3], ((k - 1) % 3 == 0), (k == 12), 1'b1, 1'b1});
            else
                check_eq("t3 c13", {b_dout, b_strobe, b_done, b_busy, b_ready}, 5'b00001);
        end
        $display("word t3 %b serialized", wb);

        // 4: LSB first, 01
        @(negedge clk);
        c_data  = 8'h01;
        c_valid = 1'b1;
        @(posedge clk);
        #1 c_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check_eq($sformatf("t4 c%0d", k),
                     {c_dout, c_strobe, c_done, c_busy, c_ready},
                     {(k == 1), (k <= 8), (k == 8), (k <= 8), 1'b1});
        end
        $display("word t4 01 serialized");

        // 5: reset during bit 4 of A5, then 3C
        wa = 8'hA5;
        @(negedge clk);
        a_data  = wa;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("t5 c%0d", k),
                     {a_dout, a_strobe, a_done, a_busy},
                     {wa[8-k], 1'b1, 1'b0, 1'b1});
        end
        reset = 1'b0;
        #1 check_eq("t5 ready in reset", a_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            @(negedge clk);
            check_eq($sformatf("t5 c%0d", k), {a_dout, a_strobe, a_done, a_busy, a_ready}, 5'b00001);
        end
        $display("word t5 a5 aborted by reset");
        run_a_word("t5b", 8'h3C);

        // 6: chain into 10011 detector, two words back-to-back
        @(negedge clk);
        d_data  = 5'b10011;
        d_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_eq($sformatf("t6 det c%0d", k), {seq_detected, d_done},
                     {(k == 6 || k == 11), (k == 5 || k == 10)});
            if (k == 1) begin
                @(posedge clk);
                #1 d_valid = 1'b0;
            end
        end
        $display("words t6 10011,10011 through detector");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
